// File: rtl/single_cycle_rv64_processor.sv
// Single-cycle RV64I subset core (add/sub/and/or/addi/ld/sd/beq): every instruction commits in one clock.
// Optional feature: define SINGLE_CYCLE_BNE_EN to decode bne (funct3 001 branches); otherwise they retire as NOP.

module sc_if_stage #(
    parameter int IMEM_DEPTH = 256,
    parameter int IW         = 8
) (
    input  logic [IW-1:0] i_index,
    output logic [31:0]   o_instruction
);
    logic [31:0] instr_mem [0:IMEM_DEPTH-1];

    assign o_instruction = instr_mem[i_index];
endmodule

module sc_id_stage (
    input  logic        i_clk,
    input  logic        i_commit,
    input  logic [31:0] i_instruction,
    input  logic [4:0]  i_write_reg,
    input  logic [63:0] i_write_data,
    input  logic        i_reg_write,
    output logic [63:0] o_read_data1,
    output logic [63:0] o_read_data2,
    output logic [63:0] o_imm_ext,
    output logic        o_reg_write,
    output logic        o_alu_src,
    output logic [1:0]  o_alu_op,
    output logic        o_branch,
    output logic        o_branch_ne,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_to_reg,
    output logic [2:0]  o_funct3,
    output logic        o_funct7_b5
);
    logic [63:0] registers [0:31];
    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;

    assign w_opcode     = i_instruction[6:0];
    assign w_rs1        = i_instruction[19:15];
    assign w_rs2        = i_instruction[24:20];
    assign o_funct3     = i_instruction[14:12];
    assign o_funct7_b5  = i_instruction[30];
    assign o_read_data1 = (w_rs1 == 5'd0) ? 64'd0 : registers[w_rs1];
    assign o_read_data2 = (w_rs2 == 5'd0) ? 64'd0 : registers[w_rs2];

    // Register file write port; contents are deliberately left uninitialised by reset.
    always_ff @(posedge i_clk) begin
        if (i_commit && i_reg_write && (i_write_reg != 5'd0)) begin
            registers[i_write_reg] <= i_write_data;
        end
    end

    // Main decoder: anything not recognised leaves every control at 0, i.e. a NOP.
    always_comb begin
        o_reg_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = 2'b00;
        o_branch     = 1'b0;
        o_branch_ne  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                case ({i_instruction[31:25], i_instruction[14:12]})
                    10'b0000000_000, 10'b0100000_000,
                    10'b0000000_111, 10'b0000000_110: begin
                        o_reg_write = 1'b1;
                        o_alu_op    = 2'b10;
                    end
                    default: o_reg_write = 1'b0;
                endcase
            end
            7'b0010011: begin
                if (i_instruction[14:12] == 3'b000) begin
                    o_reg_write = 1'b1;
                    o_alu_src   = 1'b1;
                end else begin
                    o_reg_write = 1'b0;
                end
            end
            7'b0000011: begin
                if (i_instruction[14:12] == 3'b011) begin
                    o_reg_write  = 1'b1;
                    o_alu_src    = 1'b1;
                    o_mem_read   = 1'b1;
                    o_mem_to_reg = 1'b1;
                end else begin
                    o_reg_write  = 1'b0;
                end
            end
            7'b0100011: begin
                if (i_instruction[14:12] == 3'b011) begin
                    o_alu_src   = 1'b1;
                    o_mem_write = 1'b1;
                end else begin
                    o_mem_write = 1'b0;
                end
            end
            7'b1100011: begin
                case (i_instruction[14:12])
                    3'b000: begin
                        o_branch = 1'b1;
                        o_alu_op = 2'b01;
                    end
`ifdef SINGLE_CYCLE_BNE_EN
                    3'b001: begin
                        o_branch    = 1'b1;
                        o_branch_ne = 1'b1;
                        o_alu_op    = 2'b01;
                    end
`endif
                    default: o_branch = 1'b0;
                endcase
            end
            default: o_reg_write = 1'b0;
        endcase
    end

    // Immediate generator; the B-type result is already a byte offset.
    always_comb begin
        case (w_opcode)
            7'b0010011, 7'b0000011:
                o_imm_ext = {{52{i_instruction[31]}}, i_instruction[31:20]};
            7'b0100011:
                o_imm_ext = {{52{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
            7'b1100011:
                o_imm_ext = {{51{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                             i_instruction[30:25], i_instruction[11:8], 1'b0};
            default:
                o_imm_ext = 64'd0;
        endcase
    end
endmodule

module sc_ex_stage (
    input  logic [63:0] i_pc,
    input  logic [63:0] i_read_data1,
    input  logic [63:0] i_read_data2,
    input  logic [63:0] i_imm_ext,
    input  logic        i_alu_src,
    input  logic [1:0]  i_alu_op,
    input  logic        i_branch,
    input  logic        i_branch_ne,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_b5,
    output logic [63:0] o_alu_result,
    output logic        o_zero,
    output logic        o_branch_taken,
    output logic [63:0] o_pc_next
);
    logic [63:0] w_operand_b;

    assign w_operand_b = i_alu_src ? i_imm_ext : i_read_data2;

    // ALU with alu_op-driven operation select; R-type refines it from funct3/funct7.
    always_comb begin
        case (i_alu_op)
            2'b00: o_alu_result = i_read_data1 + w_operand_b;
            2'b01: o_alu_result = i_read_data1 - w_operand_b;
            2'b10: begin
                case (i_funct3)
                    3'b000:  o_alu_result = i_funct7_b5 ? (i_read_data1 - w_operand_b)
                                                        : (i_read_data1 + w_operand_b);
                    3'b111:  o_alu_result = i_read_data1 & w_operand_b;
                    3'b110:  o_alu_result = i_read_data1 | w_operand_b;
                    default: o_alu_result = i_read_data1 + w_operand_b;
                endcase
            end
            default: o_alu_result = i_read_data1 + w_operand_b;
        endcase
    end

    assign o_zero         = (o_alu_result == 64'd0);
    assign o_branch_taken = i_branch & (o_zero ^ i_branch_ne);
    assign o_pc_next      = o_branch_taken ? (i_pc + i_imm_ext) : (i_pc + 64'd4);
endmodule

module sc_mem_stage #(
    parameter int DMEM_DEPTH = 256,
    parameter int DW         = 8
) (
    input  logic        i_clk,
    input  logic        i_commit,
    input  logic [63:0] i_alu_result,
    input  logic [63:0] i_write_data,
    input  logic        i_mem_write,
    output logic [63:0] o_read_data_mem,
    output logic [63:0] o_alu_result_mem
);
    logic [63:0]   mem [0:DMEM_DEPTH-1];
    logic [DW-1:0] w_index;

    assign w_index          = i_alu_result[DW+2:3];
    assign o_read_data_mem  = mem[w_index];
    assign o_alu_result_mem = i_alu_result;

    // Doubleword store; byte offset bits are ignored.
    always_ff @(posedge i_clk) begin
        if (i_commit && i_mem_write) begin
            mem[w_index] <= i_write_data;
        end
    end
endmodule

module sc_wb_stage (
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    input  logic        i_mem_to_reg,
    input  logic        i_mem_read,
    input  logic [63:0] i_read_data_mem,
    input  logic [63:0] i_alu_result_mem,
    output logic [4:0]  o_write_reg,
    output logic        o_reg_write_wb,
    output logic [63:0] o_write_data_reg
);
    assign o_write_reg      = i_rd;
    assign o_reg_write_wb   = i_reg_write;
    assign o_write_data_reg = (i_mem_to_reg & i_mem_read) ? i_read_data_mem : i_alu_result_mem;
endmodule

module single_cycle_rv64_processor #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [63:0] pc_current;
    logic [63:0] w_pc_next;
    logic        w_commit;
    logic [31:0] instruction;
    logic [63:0] read_data1, read_data2, imm_ext;
    logic        reg_write, alu_src, branch, w_branch_ne, mem_read, mem_write, mem_to_reg;
    logic [1:0]  alu_op;
    logic [2:0]  w_funct3;
    logic        w_funct7_b5;
    logic [63:0] alu_result, read_data_mem, alu_result_mem, write_data_reg;
    logic        zero, branch_taken, reg_write_wb;
    logic [4:0]  write_reg;

    assign w_commit = ~reset;

    // Program counter: reset wins over commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_current <= 64'd0;
        end else begin
            pc_current <= w_pc_next;
        end
    end

    sc_if_stage #(.IMEM_DEPTH(IMEM_DEPTH), .IW(IW)) if_stage (
        .i_index       (pc_current[IW+1:2]),
        .o_instruction (instruction)
    );

    sc_id_stage id_stage (
        .i_clk         (clk),
        .i_commit      (w_commit),
        .i_instruction (instruction),
        .i_write_reg   (write_reg),
        .i_write_data  (write_data_reg),
        .i_reg_write   (reg_write_wb),
        .o_read_data1  (read_data1),
        .o_read_data2  (read_data2),
        .o_imm_ext     (imm_ext),
        .o_reg_write   (reg_write),
        .o_alu_src     (alu_src),
        .o_alu_op      (alu_op),
        .o_branch      (branch),
        .o_branch_ne   (w_branch_ne),
        .o_mem_read    (mem_read),
        .o_mem_write   (mem_write),
        .o_mem_to_reg  (mem_to_reg),
        .o_funct3      (w_funct3),
        .o_funct7_b5   (w_funct7_b5)
    );

    sc_ex_stage ex_stage (
        .i_pc           (pc_current),
        .i_read_data1   (read_data1),
        .i_read_data2   (read_data2),
        .i_imm_ext      (imm_ext),
        .i_alu_src      (alu_src),
        .i_alu_op       (alu_op),
        .i_branch       (branch),
        .i_branch_ne    (w_branch_ne),
        .i_funct3       (w_funct3),
        .i_funct7_b5    (w_funct7_b5),
        .o_alu_result   (alu_result),
        .o_zero         (zero),
        .o_branch_taken (branch_taken),
        .o_pc_next      (w_pc_next)
    );

    sc_mem_stage #(.DMEM_DEPTH(DMEM_DEPTH), .DW(DW)) mem_stage (
        .i_clk            (clk),
        .i_commit         (w_commit),
        .i_alu_result     (alu_result),
        .i_write_data     (read_data2),
        .i_mem_write      (mem_write),
        .o_read_data_mem  (read_data_mem),
        .o_alu_result_mem (alu_result_mem)
    );

    sc_wb_stage wb_stage (
        .i_rd             (instruction[11:7]),
        .i_reg_write      (reg_write),
        .i_mem_to_reg     (mem_to_reg),
        .i_mem_read       (mem_read),
        .i_read_data_mem  (read_data_mem),
        .i_alu_result_mem (alu_result_mem),
        .o_write_reg      (write_reg),
        .o_reg_write_wb   (reg_write_wb),
        .o_write_data_reg (write_data_reg)
    );
endmodule

// File: tb/tb_single_cycle_rv64_processor.sv
// Directed bench for single_cycle_rv64_processor: preloads memories/registers hierarchically and
// checks architectural state after each committed instruction.
module tb_single_cycle_rv64_processor;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    single_cycle_rv64_processor dut (
        .clk   (clk),
        .reset (reset)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.if_stage.instr_mem[i] = 32'h00000013;
            dut.mem_stage.mem[i]      = 64'd0;
        end
        for (int i = 0; i < 32; i++) dut.id_stage.registers[i] = 64'd0;
        dut.if_stage.instr_mem[0]  = 32'h00073A03; // ld  x20,0(x14)
        dut.if_stage.instr_mem[1]  = 32'h00530AB3; // add x21,x6,x5
        dut.if_stage.instr_mem[2]  = 32'h01583023; // sd  x21,0(x16)
        dut.if_stage.instr_mem[3]  = 32'h01288863; // beq x17,x18,16
        dut.if_stage.instr_mem[7]  = 32'h00500013; // addi x0,x0,5
        dut.if_stage.instr_mem[8]  = 32'hFFFFFFFF; // undefined opcode
        dut.if_stage.instr_mem[9]  = 32'hFFD28393; // addi x7,x5,-3
        dut.if_stage.instr_mem[10] = 32'h40628433; // sub x8,x5,x6
        dut.if_stage.instr_mem[11] = 32'h0062F4B3; // and x9,x5,x6
        dut.if_stage.instr_mem[12] = 32'h0062E533; // or  x10,x5,x6
        dut.if_stage.instr_mem[13] = 32'h026285B3; // funct7 0000001: undefined
        dut.if_stage.instr_mem[14] = 32'h00373603; // ld  x12,3(x14)
        dut.if_stage.instr_mem[15] = 32'h00629463; // bne x5,x6,8
        dut.id_stage.registers[5]  = 64'd5;
        dut.id_stage.registers[6]  = 64'd6;
        dut.id_stage.registers[11] = 64'h55;
        dut.id_stage.registers[14] = 64'h100;
        dut.id_stage.registers[16] = 64'h200;
        dut.id_stage.registers[17] = 64'd1;
        dut.id_stage.registers[18] = 64'd1;
        dut.id_stage.registers[20] = 64'hDEAD;
        dut.id_stage.registers[31] = 64'h31;
        dut.mem_stage.mem[0]       = 64'hA5A5;
        dut.mem_stage.mem[32]      = 64'h1234567890ABCDEF;
        step();
        step();
        total++;
        if (dut.pc_current !== 64'd0) begin
            bad++; $display("FAIL reset_pc got=%h exp=%h", dut.pc_current, 64'd0);
        end
        total++;
        if (dut.id_stage.registers[20] !== 64'hDEAD) begin
            bad++; $display("FAIL reset_no_regwrite got=%h exp=%h", dut.id_stage.registers[20], 64'hDEAD);
        end
        total++;
        if (dut.mem_stage.mem[32] !== 64'h1234567890ABCDEF) begin
            bad++; $display("FAIL reset_mem_kept got=%h exp=%h", dut.mem_stage.mem[32], 64'h1234567890ABCDEF);
        end
        reset = 1'b0;
    endtask

    task automatic test_load();
        step();
        total++;
        if (dut.id_stage.registers[20] !== 64'h1234567890ABCDEF) begin
            bad++; $display("FAIL ld_data got=%h exp=%h", dut.id_stage.registers[20], 64'h1234567890ABCDEF);
        end
        total++;
        if (dut.pc_current !== 64'h4) begin
            bad++; $display("FAIL ld_pc got=%h exp=%h", dut.pc_current, 64'h4);
        end
    endtask

    task automatic test_add_store();
        step();
        total++;
        if (dut.id_stage.registers[21] !== 64'hB) begin
            bad++; $display("FAIL add_x21 got=%h exp=%h", dut.id_stage.registers[21], 64'hB);
        end
        step();
        total++;
        if (dut.mem_stage.mem[64] !== 64'hB) begin
            bad++; $display("FAIL sd_mem got=%h exp=%h", dut.mem_stage.mem[64], 64'hB);
        end
        total++;
        if (dut.id_stage.registers[16] !== 64'h200 || dut.id_stage.registers[21] !== 64'hB) begin
            bad++; $display("FAIL sd_regs got=%h/%h exp=%h/%h", dut.id_stage.registers[16],
                            dut.id_stage.registers[21], 64'h200, 64'hB);
        end
        total++;
        if (dut.pc_current !== 64'hC) begin
            bad++; $display("FAIL sd_pc got=%h exp=%h", dut.pc_current, 64'hC);
        end
    endtask

    task automatic test_branch_taken();
        step();
        total++;
        if (dut.pc_current !== 64'h1C) begin
            bad++; $display("FAIL beq_taken_pc got=%h exp=%h", dut.pc_current, 64'h1C);
        end
    endtask

    task automatic test_nop_and_undefined();
        step();
        total++;
        if (dut.id_stage.registers[0] !== 64'd0 || dut.pc_current !== 64'h20) begin
            bad++; $display("FAIL x0_write got=%h pc=%h exp=%h pc=%h", dut.id_stage.registers[0],
                            dut.pc_current, 64'd0, 64'h20);
        end
        step();
        total++;
        if (dut.pc_current !== 64'h24) begin
            bad++; $display("FAIL undef_pc got=%h exp=%h", dut.pc_current, 64'h24);
        end
        total++;
        if (dut.id_stage.registers[31] !== 64'h31 || dut.mem_stage.mem[0] !== 64'hA5A5 ||
            dut.mem_stage.mem[64] !== 64'hB) begin
            bad++; $display("FAIL undef_state got=%h/%h/%h exp=%h/%h/%h", dut.id_stage.registers[31],
                            dut.mem_stage.mem[0], dut.mem_stage.mem[64], 64'h31, 64'hA5A5, 64'hB);
        end
    endtask

    task automatic test_alu_ops();
        logic [63:0] exp_v [0:3];
        exp_v[0] = 64'd2;
        exp_v[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_v[2] = 64'd4;
        exp_v[3] = 64'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (dut.id_stage.registers[7+i] !== exp_v[i]) begin
                bad++; $display("FAIL alu_op%0d got=%h exp=%h", i, dut.id_stage.registers[7+i], exp_v[i]);
            end
        end
        total++;
        if (dut.pc_current !== 64'h34) begin
            bad++; $display("FAIL alu_pc got=%h exp=%h", dut.pc_current, 64'h34);
        end
        step();
        total++;
        if (dut.id_stage.registers[11] !== 64'h55 || dut.pc_current !== 64'h38) begin
            bad++; $display("FAIL bad_funct got=%h pc=%h exp=%h pc=%h", dut.id_stage.registers[11],
                            dut.pc_current, 64'h55, 64'h38);
        end
        step();
        total++;
        if (dut.id_stage.registers[12] !== 64'h1234567890ABCDEF) begin
            bad++; $display("FAIL ld_misaligned got=%h exp=%h", dut.id_stage.registers[12], 64'h1234567890ABCDEF);
        end
    endtask

    task automatic test_bne();
        logic [63:0] exp_pc;
`ifdef SINGLE_CYCLE_BNE_EN
        exp_pc = 64'h44;
`else
        exp_pc = 64'h40;
`endif
        step();
        total++;
        if (dut.pc_current !== exp_pc) begin
            bad++; $display("FAIL bne_pc got=%h exp=%h", dut.pc_current, exp_pc);
        end
    endtask

    task automatic test_branch_not_taken();
        reset = 1'b1;
        dut.id_stage.registers[18] = 64'd2;
        step();
        total++;
        if (dut.pc_current !== 64'd0) begin
            bad++; $display("FAIL rereset_pc got=%h exp=%h", dut.pc_current, 64'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (dut.pc_current !== 64'h10) begin
            bad++; $display("FAIL beq_not_taken_pc got=%h exp=%h", dut.pc_current, 64'h10);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_load();
        test_add_store();
        test_branch_taken();
        test_nop_and_undefined();
        test_alu_ops();
        test_bne();
        test_branch_not_taken();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
